// File: rtl/adder_arbiter_pkg.sv
// Shared constants, ID-width helper and response record for the adder arbiter.
package adder_arb_pkg;

    localparam int ADDER_WIDTH   = 32;
    localparam int ADDER_NUM_REQ = 2;

    // Requester-ID width, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    localparam int ADDER_ID_W = clog2_min1(ADDER_NUM_REQ);

    typedef struct packed {
        logic [ADDER_ID_W-1:0]  id;
        logic [ADDER_WIDTH-1:0] sum;
        logic                   carry;
        logic                   ovf;
    } adder_rsp_t;

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bus between requesters, the adder arbiter and its result consumer.
interface adder_arbiter_if
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = ADDER_NUM_REQ,
    parameter int WIDTH   = ADDER_WIDTH,
    parameter int ID_W    = clog2_min1(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       req_sub;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_carry;
    logic                     rsp_ovf;

    modport master (
        output req_valid, req_sub, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf
    );

    modport slave (
        input  req_valid, req_sub, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf
    );

endinterface

// File: rtl/adder_arbiter_core.sv
// Combinational WIDTH-bit add/subtract; subtraction is a + ~b + 1.
// Overflow detection is compiled only when ADDER_ARB_OVF_EN is defined.
module adder_core
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff        = sub ? ~b : b;
    assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

`ifdef ADDER_ARB_OVF_EN
    assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath, with a one-entry result register.
// Optional signed-overflow output enabled by defining ADDER_ARB_OVF_EN.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = ADDER_NUM_REQ,
    parameter int WIDTH   = ADDER_WIDTH,
    parameter int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic           clk,
    input  logic           rst_n,
    adder_arbiter_if.slave bus
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_carry_q, rsp_carry_d;

    logic [WIDTH-1:0]   a_arr [NUM_REQ];
    logic [WIDTH-1:0]   b_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    sel_idx;
    logic               found;
    logic               slot_free;
    logic               transfer;

    logic [WIDTH-1:0] core_sum;
    logic             core_carry;
    logic             core_ovf;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = bus.req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign slot_free = (state_q == ST_EMPTY) || bus.rsp_ready;

    // First valid requester at or after ptr, wrapping; gated off while in reset.
    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        sel_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && bus.req_valid[ID_W'(idx)]) begin
                found   = 1'b1;
                sel_idx = ID_W'(idx);
            end
        end
        if (found && slot_free && rst_n) begin
            grant[sel_idx] = 1'b1;
        end
    end

    assign transfer = |grant;

    adder_core #(.WIDTH(WIDTH)) u_core (
        .a     (a_arr[sel_idx]),
        .b     (b_arr[sel_idx]),
        .sub   (bus.req_sub[sel_idx]),
        .sum   (core_sum),
        .carry (core_carry),
        .ovf   (core_ovf)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        if (transfer) begin
            state_d     = ST_FULL;
            ptr_d       = (int'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + 1'b1;
            rsp_id_d    = sel_idx;
            rsp_sum_d   = core_sum;
            rsp_carry_d = core_carry;
        end else if ((state_q == ST_FULL) && bus.rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            ptr_q       <= '0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end

`ifdef ADDER_ARB_OVF_EN
    logic rsp_ovf_q, rsp_ovf_d;

    assign rsp_ovf_d = transfer ? core_ovf : rsp_ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_ovf_q <= 1'b0;
        end else begin
            rsp_ovf_q <= rsp_ovf_d;
        end
    end

    assign bus.rsp_ovf = rsp_ovf_q;
`else
    logic ovf_unused;
    assign ovf_unused  = core_ovf;
    assign bus.rsp_ovf = 1'b0;
`endif

    assign bus.req_ready = grant;
    assign bus.rsp_valid = (state_q == ST_FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed vectors, stall/reset sequences
// and randomized traffic against an arithmetic reference model.
module tb_adder_arbiter;
    import adder_arb_pkg::*;

    localparam int N = 2;
    localparam int W = 32;
`ifdef ADDER_ARB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adder_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    adder_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];
    logic [N-1:0] pend;
    logic [N-1:0] subv;

    bit         m_valid;
    int         m_ptr;
    adder_rsp_t m_rsp;

    typedef struct {
        int          req;
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive();
        bus.req_valid = pend;
        bus.req_sub   = subv;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = op_a[i];
            bus.req_b[i*W +: W] = op_b[i];
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ptr   = 0;
        m_rsp   = '0;
    endtask

    function automatic adder_rsp_t ref_op(input int id, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic sub);
        adder_rsp_t res;
        longint ua, ub, r, sa, sb, sr;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        r  = sub ? ua - ub : ua + ub;
        sr = sub ? sa - sb : sa + sb;
        res.id    = ADDER_ID_W'(id);
        res.sum   = r[31:0];
        res.carry = sub ? (ua >= ub) : ((r >> 32) != 0);
        res.ovf   = OVF_ON && ((sr > SMAX) || (sr < SMIN));
        return res;
    endfunction

    function automatic int exp_grant();
        int idx;
        if (!rst_n) return -1;
        if (m_valid && !bus.rsp_ready) return -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (bus.req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check_rsp(input string name);
        check(name, {bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf},
              {m_valid, m_rsp});
    endtask

    // Called at a falling edge: drive, check grant, advance one clock, check result.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_rdy;
        drive();
        #1;
        g = exp_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", bus.req_ready, exp_rdy);
        @(posedge clk);
        if (g >= 0) begin
            m_rsp   = ref_op(g, op_a[g], op_b[g], subv[g]);
            m_valid = 1'b1;
            m_ptr   = (g + 1) % N;
            pend[g] = 1'b0;
            $display("xfer id=%0d a=%h b=%h sub=%0d -> sum=%h carry=%0d ovf=%0d",
                     g, op_a[g], op_b[g], subv[g], m_rsp.sum, m_rsp.carry, m_rsp.ovf);
        end else if (m_valid && bus.rsp_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_rsp("rsp");
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        tbl[0] = '{0, 1'b0, 32'd2,          32'd20, 32'd22,         1'b0, 1'b0};
        tbl[1] = '{1, 1'b0, 32'hFFFF_FFFF,  32'd1,  32'h0000_0000,  1'b1, 1'b0};
        tbl[2] = '{1, 1'b0, 32'h7FFF_FFFF,  32'd1,  32'h8000_0000,  1'b0, OVF_ON};
        tbl[3] = '{0, 1'b1, 32'd5,          32'd25, 32'hFFFF_FFEC,  1'b0, 1'b0};
        tbl[4] = '{0, 1'b1, 32'd25,         32'd5,  32'd20,         1'b1, 1'b0};

        // Reset with both requesters asserting
        rst_n = 1'b0;
        pend  = '1;
        subv  = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        bus.rsp_ready = 1'b1;
        drive();
        model_reset();
        #3;
        check("reset_ready", bus.req_ready, '0);
        check_rsp("reset_rsp");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Alternating grants with both requesters continuously valid
        for (int i = 0; i < 8; i++) begin
            pend    = '1;
            op_a[0] = W'(i);
            op_b[0] = 32'd100;
            op_a[1] = W'(i * 3);
            op_b[1] = 32'd7;
            subv    = 2'b10;
            cycle();
            check("alt_id", bus.rsp_id, i % 2);
        end

        // Directed arithmetic vectors
        for (int t = 0; t < 5; t++) begin
            pend              = '0;
            pend[tbl[t].req]  = 1'b1;
            op_a[tbl[t].req]  = tbl[t].a;
            op_b[tbl[t].req]  = tbl[t].b;
            subv[tbl[t].req]  = tbl[t].sub;
            bus.rsp_ready     = 1'b1;
            cycle();
            check("tbl_result", {bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf},
                  {1'b1, 1'(tbl[t].req), tbl[t].sum, tbl[t].carry, tbl[t].ovf});
        end

        // Backpressure: three stalled cycles, then release
        for (int i = 0; i < 3; i++) begin
            pend          = '1;
            bus.rsp_ready = 1'b0;
            cycle();
            check("stall_sum", bus.rsp_sum, 32'd20);
        end
        pend          = '1;
        bus.rsp_ready = 1'b1;
        cycle();
        check("resume_id", bus.rsp_id, 1);

        // Randomized traffic
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(3) != 0) begin
                    pend[i] = 1'b1;
                    op_a[i] = rnd_val();
                    op_b[i] = rnd_val();
                    subv[i] = 1'($urandom_range(1));
                end
            end
            bus.rsp_ready = ($urandom_range(3) != 0);
            cycle();
        end

        // Reset in the middle of a held result
        pend          = '1;
        bus.rsp_ready = 1'b1;
        cycle();
        pend          = '1;
        bus.rsp_ready = 1'b0;
        drive();
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf}, '0);
        check("midrst_ready", bus.req_ready, '0);
        model_reset();
        @(negedge clk);
        rst_n         = 1'b1;
        pend          = 2'b10;
        op_a[1]       = 32'd40;
        op_b[1]       = 32'd2;
        subv[1]       = 1'b0;
        bus.rsp_ready = 1'b1;
        cycle();
        check("post_rst_id1", {bus.rsp_id, bus.rsp_sum}, {1'b1, 32'd42});
        pend = '1;
        cycle();
        check("post_rst_id0", bus.rsp_id, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one 32-bit add/subtract datapath among several requesters, such as the PC incrementer, branch-target calculation and ALU. Each accepted operation returns one registered result one cycle later, tagged with the requester's ID. A one-entry output register with backpressure decouples consumers from the datapath.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- WIDTH, 32, operand/result width
- ID_W, $clog2(NUM_REQ), requester-ID width (min 1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; asynchronous assert, active-low
- req_valid  input  NUM_REQ  request pending, one bit per requester
- req_ready  output  NUM_REQ  grant; one-hot or zero
- req_sub  input  NUM_REQ  per-requester op: 0 = a+b, 1 = a−b
- req_a  input  NUM_REQ*WIDTH  packed operand A; requester i at [i*WIDTH +: WIDTH]
- req_b  input  NUM_REQ*WIDTH  packed operand B, same packing
- rsp_valid  output  1  result register holds a valid result
- rsp_ready  input  1  consumer accepts the result this cycle
- rsp_id  output  ID_W  index of the requester that produced the result
- rsp_sum  output  WIDTH  result, modulo 2^WIDTH
- rsp_carry  output  1  carry-out of the addition (for sub, 1 means no borrow)
- rsp_ovf  output  1  signed two's-complement overflow

## Operation
- Subtraction is a + ~b + 1 on the single shared adder. rsp_carry is bit WIDTH of the (WIDTH+1)-bit sum.
- Slot free: slot_free = !rsp_valid || rsp_ready.
- Arbitration, applied only when slot_free:
  - Scan requesters starting at index ptr, wrapping modulo NUM_REQ.
  - Grant the first one with req_valid set: drive its req_ready high and all others low.
- When slot is not free, all req_ready are 0.
- Transfer: when req_valid[i] && req_ready[i] at a rising edge:
  - Result, carry, overflow and ID = i load into the output register.
  - rsp_valid goes to 1.
  - ptr becomes (i+1) mod NUM_REQ.
- Consume: when rsp_valid && rsp_ready and no transfer occurs in the same cycle, rsp_valid goes to 0. If a transfer does occur in the same cycle, the register reloads and rsp_valid stays 1.
- Stability: while rsp_valid && !rsp_ready, all rsp_* outputs hold stable.
- Idle: with no req_valid asserted, ptr holds.
- Requesters must not make req_valid depend on req_ready. A requester holds its operands and req_sub stable until granted.
- State summary: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY→FULL on transfer.
  - FULL→EMPTY on consume without transfer.
  - FULL→FULL on stall, or on consume plus transfer.

## Timing
- req_ready is combinational from req_valid, ptr, rsp_valid and rsp_ready. There is no combinational path from req_a/req_b to any output.
- Latency is 1 cycle: a result accepted at edge N is visible on rsp_* after edge N.
- Throughput is one operation per cycle while rsp_ready is held high.
- Reset (rst_n low, asynchronous) sets:
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, rsp_ovf=0
  - ptr=0, so requester 0 has priority first
  - req_ready=0 while rst_n is low
- Reset mid-operation discards any held result with no response. The first grant after release follows ptr=0.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ−1,0. No requester waits more than NUM_REQ−1 transfers.
- Wrap-around: the sum wraps modulo 2^WIDTH. 0xFFFFFFFF+1 gives sum 0, carry 1.

## Configuration
- ADDER_ARB_OVF_EN defined:
  - rsp_ovf is registered alongside the result.
  - rsp_ovf = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), where b' = b for add and ~b for sub.
- ADDER_ARB_OVF_EN undefined:
  - The overflow logic is not compiled.
  - rsp_ovf is tied to 0 and the port remains present.

## Structure
- Shared package adder_arb_pkg holds:
  - default constants ADDER_WIDTH=32 and ADDER_NUM_REQ=2
  - function clog2_min1 for ID_W
  - typedef of the response record {id, sum, carry, ovf}
- Sub-module adder_core: purely combinational WIDTH-bit add/sub with inputs a, b, sub and outputs sum, carry, ovf. It is instantiated once; all arbitration and registering stays in adder_arbiter.

## Test plan
- After reset, req_valid=2'b11, rsp_ready=1, both requesters hold their operands → grants alternate 0,1,0,1 every cycle and each rsp_id matches the requester granted one cycle earlier.
- Requester 0 sends a=2, b=20, sub=0 → next cycle rsp_valid=1, rsp_sum=22, rsp_carry=0, rsp_ovf=0, rsp_id=0.
- Requester 1 sends a=0xFFFFFFFF, b=1, sub=0 → rsp_sum=0, rsp_carry=1, rsp_ovf=0. Then a=0x7FFFFFFF, b=1 → rsp_sum=0x80000000, rsp_ovf=1 (0 when ADDER_ARB_OVF_EN is undefined).
- Requester 0 sends a=5, b=25, sub=1 → rsp_sum=0xFFFFFFEC, rsp_carry=0. Then a=25, b=5, sub=1 → rsp_sum=20, rsp_carry=1.
- Hold rsp_ready=0 for 3 cycles with both requesters valid → req_ready=0 and rsp_* stable. Raise rsp_ready → the held result is consumed and the next grant goes to the other requester in the same cycle.
- Pull rst_n low mid-stream while rsp_valid=1 → all outputs go to 0 immediately. After release with only requester 1 valid, it is granted and the next grant is evaluated starting at ptr=0.
